mips32_mem_responder: RTL

Single-port word-addressed memory target that answers load/store requests issued by the mips32 pipeline's MEM stage over a valid/ready request and response handshake. It replaces the core-internal data array, so the memory can sit outside the core with configurable wait states. Only one transaction is outstanding at a time. Every request, read or write, gets exactly one response beat.

---
 rtl/mips32_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips32_mem_responder.sv
// Word-addressed single-port memory target for the mips32 MEM stage.
// Accepts one load/store at a time, waits LATENCY cycles, then returns
// exactly one response beat. Out-of-range addresses answer with rsp_err.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. The requester must hold its request
// while req_ready is 0, and this block holds rsp_rdata/rsp_err stable
// while rsp_valid is 1 until the response transfers.
module mips32_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int LATENCY = 2
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_accept;
    logic            w_commit;
    logic            w_acc_we;
    logic [AW-1:0]   w_acc_addr;
    logic [DW-1:0]   w_acc_wdata;
    logic            w_in_range;
    logic [IW-1:0]   w_idx;
    logic [DW-1:0]   w_rsp_rdata;
    logic            w_rsp_err;

    // Select the access operands and decide when the array access happens.
    // With zero wait states the access happens on the accept edge itself, so
    // it must use the live request rather than the not-yet-latched copy.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && req_valid;
        w_acc_we    = ZERO_LAT ? req_we    : r_we;
        w_acc_addr  = ZERO_LAT ? req_addr  : r_addr;
        w_acc_wdata = ZERO_LAT ? req_wdata : r_wdata;
        w_commit    = rst_n && (ZERO_LAT ? w_accept
                                         : ((r_state == S_WAIT) && (r_cnt == CW'(1))));
        // Full-width compare so that high address bits never alias low words.
        w_in_range  = ({1'b0, w_acc_addr} < (AW+1)'(DEPTH));
        w_idx       = w_acc_addr[IW-1:0];
        w_rsp_err   = !w_in_range;
        w_rsp_rdata = (w_in_range && !w_acc_we) ? r_mem[w_idx] : '0;
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk1) begin
        if (w_commit && w_in_range && w_acc_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_cnt     <= CW'(LATENCY);
                        req_ready <= 1'b0;
                        if (ZERO_LAT) begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= w_rsp_rdata;
                            rsp_err   <= w_rsp_err;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= w_rsp_rdata;
                        rsp_err   <= w_rsp_err;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state   <= S_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
